sdram_wr_fifo_drain: RTL and testbench

Single-clock read-side controller for the SDRAM write-path FIFO. It watches the FIFO fill level and requests an SDRAM write burst from the command arbiter when enough words are buffered. After grant it pops exactly one burst of words out of the FIFO and streams them to the controller's write-data port. It tracks a circular word address inside a configured SDRAM region. It sits between the FIFO read port (`rd_req`/`rd_data`/`rd_use_num`) and the SDRAM arbiter.

---
 rtl/sdram_wr_fifo_drain.sv | 186 ++++++++++++++++++
 tb/tb_sdram_wr_fifo_drain.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wr_fifo_drain.sv
// ---------------------------------------------------------------------------
// sdram_wr_fifo_drain
//
// Read-side controller for the SDRAM write-path FIFO. It waits until enough
// words are buffered, requests a write burst from the SDRAM arbiter and, once
// granted, pops exactly one burst of words and streams them to the write-data
// port. Burst start addresses walk a circular word region
// [BASE_ADDR, END_ADDR).
//
// Optional feature macro: SDRAM_WR_FLUSH_EN
//   When it is defined, a partial burst (1..BURST_LEN-1 words) may be started
//   while `flush` is high. When it is undefined, `flush` is ignored.
//
// Parameters:
//   BURST_LEN  words per full burst (1..256)
//   ADDR_W     SDRAM word-address width
//   BASE_ADDR  first word address of the ring region
//   END_ADDR   one past the last word of the ring region
//
// Ports:
//   clk              single clock (FIFO read clock)
//   clr_n            asynchronous active-low reset
//   enable           allows new bursts to start
//   flush            level; allows a partial burst when the feature is built in
//   fifo_rd_req      FIFO pop strobe
//   fifo_rd_data     FIFO output word, valid the cycle after fifo_rd_req
//   fifo_rd_use_num  FIFO fill level
//   wr_req           burst request to the arbiter
//   wr_ack           single-cycle grant, only honoured while requesting
//   wr_addr          burst start address
//   wr_len           words in the current burst
//   wr_data          write word (combinational pass-through of fifo_rd_data)
//   wr_data_valid    wr_data is valid this cycle
//   wr_done          one-cycle pulse when a burst completes
//   busy             high in any state other than IDLE
// ---------------------------------------------------------------------------
module sdram_wr_fifo_drain #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned END_ADDR  = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              enable,
    input  logic              flush,
    output logic              fifo_rd_req,
    input  logic [15:0]       fifo_rd_data,
    input  logic [9:0]        fifo_rd_use_num,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_len,
    output logic [15:0]       wr_data,
    output logic              wr_data_valid,
    output logic              wr_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        READ,
        DRAIN
    } state_e;

    localparam logic [9:0] BURST_NUM  = 10'(BURST_LEN);
    localparam logic [8:0] BURST_LEN9 = 9'(BURST_LEN);
    // END_ADDR may equal 2**ADDR_W, so address arithmetic carries one extra bit.
    localparam logic [ADDR_W:0] BASE_EXT = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] END_EXT  = (ADDR_W + 1)'(END_ADDR);

    state_e            state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [8:0]        wr_len_q, wr_len_d;
    logic              wr_req_q, wr_req_d;
    logic              fifo_rd_req_q, fifo_rd_req_d;
    logic              wr_data_valid_q, wr_data_valid_d;
    logic              wr_done_q, wr_done_d;
    logic              busy_q, busy_d;

    logic              start_full;
    logic              start_part;
    logic [ADDR_W:0]   addr_sum;
    logic [ADDR_W:0]   addr_next;

    assign start_full = enable && (fifo_rd_use_num >= BURST_NUM);

`ifdef SDRAM_WR_FLUSH_EN
    assign start_part = enable && flush
                        && (fifo_rd_use_num != 10'd0)
                        && (fifo_rd_use_num < BURST_NUM);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign start_part   = 1'b0;
`endif

    // Ring advance: wrap the overshoot past END_ADDR back onto BASE_ADDR.
    assign addr_sum  = {1'b0, wr_addr_q} + (ADDR_W + 1)'(wr_len_q);
    assign addr_next = (addr_sum >= END_EXT) ? (addr_sum - END_EXT + BASE_EXT) : addr_sum;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_len_d  = wr_len_q;

        unique case (state_q)
            IDLE: begin
                // A full burst wins over a flush when both are possible.
                if (start_full) begin
                    state_d  = REQ;
                    wr_len_d = BURST_LEN9;
                end else if (start_part) begin
                    state_d  = REQ;
                    wr_len_d = fifo_rd_use_num[8:0];
                end
            end
            REQ: begin
                // The request stays up until granted, even if enable drops.
                if (wr_ack) begin
                    state_d = READ;
                    cnt_d   = wr_len_q;
                end
            end
            READ: begin
                cnt_d = cnt_q - 9'd1;
                if (cnt_q == 9'd1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d   = IDLE;
                wr_addr_d = addr_next[ADDR_W-1:0];
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        wr_req_d        = (state_d == REQ);
        fifo_rd_req_d   = (state_d == READ);
        busy_d          = (state_d != IDLE);
        wr_data_valid_d = fifo_rd_req_q;
        wr_done_d       = (state_q == DRAIN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q         <= IDLE;
            cnt_q           <= 9'd0;
            wr_addr_q       <= BASE_EXT[ADDR_W-1:0];
            wr_len_q        <= 9'd0;
            wr_req_q        <= 1'b0;
            fifo_rd_req_q   <= 1'b0;
            wr_data_valid_q <= 1'b0;
            wr_done_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wr_addr_q       <= wr_addr_d;
            wr_len_q        <= wr_len_d;
            wr_req_q        <= wr_req_d;
            fifo_rd_req_q   <= fifo_rd_req_d;
            wr_data_valid_q <= wr_data_valid_d;
            wr_done_q       <= wr_done_d;
            busy_q          <= busy_d;
        end
    end

    assign fifo_rd_req   = fifo_rd_req_q;
    assign wr_req        = wr_req_q;
    assign wr_addr       = wr_addr_q;
    assign wr_len        = wr_len_q;
    assign wr_data       = fifo_rd_data;
    assign wr_data_valid = wr_data_valid_q;
    assign wr_done       = wr_done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sdram_wr_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_sdram_wr_fifo_drain
//
// Bench for sdram_wr_fifo_drain on a small ring (BASE 16, END 32, bursts of 8)
// so address wrap happens often. A behavioural FIFO supplies random words;
// every pushed word and every burst length the stimulus makes possible is
// queued as an expectation. A monitor pops these as the DUT presents requests
// and data, and checks the burst timing relative to the grant cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_wr_fifo_drain;

    localparam int BL   = 8;
    localparam int AW   = 24;
    localparam int BASE = 16;
    localparam int ENDA = 32;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          wr_ack = 1'b0;
    logic          fifo_rd_req;
    logic [15:0]   fifo_rd_data = 16'h0;
    logic [9:0]    fifo_rd_use_num = 10'd0;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_len;
    logic [15:0]   wr_data;
    logic          wr_data_valid;
    logic          wr_done;
    logic          busy;

    sdram_wr_fifo_drain #(
        .BURST_LEN (BL),
        .ADDR_W    (AW),
        .BASE_ADDR (BASE),
        .END_ADDR  (ENDA)
    ) dut (
        .clk             (clk),
        .clr_n           (clr_n),
        .enable          (enable),
        .flush           (flush),
        .fifo_rd_req     (fifo_rd_req),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_rd_use_num (fifo_rd_use_num),
        .wr_req          (wr_req),
        .wr_ack          (wr_ack),
        .wr_addr         (wr_addr),
        .wr_len          (wr_len),
        .wr_data         (wr_data),
        .wr_data_valid   (wr_data_valid),
        .wr_done         (wr_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [15:0] fifo_mem[$];
    logic [15:0] exp_words[$];
    int          exp_len[$];
    int          push_total = 0;
    int          credit = 0;
    int          req_seen = 0;
    bit          in_burst = 1'b0;
    int          model_addr = BASE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ring_next(input int a, input int n);
        int s;
        s = a + n;
        if (s >= ENDA) s = BASE + (s - ENDA);
        return s;
    endfunction

    // Behavioural FIFO: registered read data, fill level updated every edge.
    int          pushed = 0;
    logic [15:0] new_word;
    always @(posedge clk) begin
        if (!clr_n) begin
            fifo_mem.delete();
            exp_words.delete();
            pushed = push_total;
            fifo_rd_use_num <= 10'd0;
        end else begin
            if (fifo_rd_req && fifo_mem.size() > 0) begin
                fifo_rd_data <= fifo_mem.pop_front();
            end
            while (pushed < push_total) begin
                new_word = 16'($urandom);
                fifo_mem.push_back(new_word);
                exp_words.push_back(new_word);
                pushed++;
            end
            fifo_rd_use_num <= 10'(fifo_mem.size());
        end
    end

    // Arbiter: grant 0..3 cycles after the request appears, plus stray grants
    // while nothing is requested.
    initial begin : arbiter
        int dly;
        dly = -1;
        forever begin
            @(negedge clk);
            wr_ack = 1'b0;
            if (!wr_req) begin
                dly = -1;
                if ($urandom_range(0, 15) == 0) wr_ack = 1'b1;
            end else begin
                if (dly < 0) dly = $urandom_range(0, 3);
                if (dly == 0) wr_ack = 1'b1;
                dly--;
            end
        end
    end

    // Monitor: samples 2 ns after the falling edge.
    initial begin : monitor
        int  cyc;
        int  t_ack;
        int  cur_len;
        int  k;
        int  nxt;
        bit  acked;
        cyc = 0; t_ack = 0; cur_len = 0; acked = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!clr_n) begin
                check("reset_ctrl_outputs", 32'({wr_req, fifo_rd_req, wr_data_valid, wr_done, busy}), 32'd0);
                check("reset_wr_len", 32'(wr_len), 32'd0);
                check("reset_wr_addr", 32'(wr_addr), 32'(BASE));
                in_burst   = 1'b0;
                acked      = 1'b0;
                model_addr = BASE;
            end else begin
                if (wr_data_valid) begin
                    check("data_expected", 32'(exp_words.size() != 0), 32'd1);
                    if (exp_words.size() != 0) check("wr_data", 32'(wr_data), 32'(exp_words.pop_front()));
                end
                if (in_burst && acked) begin
                    k = cyc - t_ack;
                    check("fifo_rd_req_timing", 32'(fifo_rd_req), 32'(k >= 1 && k <= cur_len));
                    check("wr_data_valid_timing", 32'(wr_data_valid), 32'(k >= 2 && k <= cur_len + 1));
                    check("wr_done_timing", 32'(wr_done), 32'(k == cur_len + 2));
                    check("wr_req_after_ack", 32'(wr_req), 32'd0);
                    check("busy_timing", 32'(busy), 32'(k <= cur_len + 1));
                    if (k == cur_len + 2) begin
                        nxt = ring_next(model_addr, cur_len);
                        check("wr_addr_advance", 32'(wr_addr), 32'(nxt));
                        model_addr = nxt;
                        in_burst   = 1'b0;
                        acked      = 1'b0;
                    end
                end else begin
                    if (!in_burst && wr_req) begin
                        req_seen++;
                        check("req_expected", 32'(exp_len.size() != 0), 32'd1);
                        cur_len = (exp_len.size() != 0) ? exp_len.pop_front() : int'(wr_len);
                        check("req_wr_len", 32'(wr_len), 32'(cur_len));
                        check("req_wr_addr", 32'(wr_addr), 32'(model_addr));
                        in_burst = 1'b1;
                        acked    = 1'b0;
                    end
                    if (in_burst) begin
                        check("req_held", 32'(wr_req), 32'd1);
                        check("req_len_stable", 32'(wr_len), 32'(cur_len));
                        check("req_addr_stable", 32'(wr_addr), 32'(model_addr));
                        check("req_no_pop", 32'({fifo_rd_req, wr_data_valid, wr_done, ~busy}), 32'd0);
                        if (wr_ack) begin
                            acked = 1'b1;
                            t_ack = cyc;
                        end
                    end else begin
                        check("idle_outputs", 32'({fifo_rd_req, wr_data_valid, wr_done, busy}), 32'd0);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pushes n words and records every full burst those words make possible.
    task automatic push_words(input int n);
        push_total += n;
        credit     += n;
        while (credit >= BL) begin
            exp_len.push_back(BL);
            credit -= BL;
        end
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_len.size() == 0 && !in_burst && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_drain_done"}, 32'(ok), 32'd1);
        cycles(3);
        check({name, "_residual_words"}, 32'(exp_words.size()), 32'(credit));
    endtask

    task automatic expect_no_req(input string name, input int n);
        int r;
        r = req_seen;
        cycles(n);
        check({name, "_no_request"}, 32'(req_seen - r), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin : stimulus
        bit ok;
        clr_n = 1'b0;
        cycles(3);
        clr_n = 1'b1;
        cycles(2);

        // Below threshold, flush low: nothing happens.
        enable = 1'b1;
        push_words(BL - 1);
        expect_no_req("below_threshold", 20);

        // Threshold met but disabled: nothing happens; enabling starts it.
        enable = 1'b0;
        push_words(1);
        expect_no_req("disabled", 20);
        drain("first_burst");

        // Partial flush.
        push_words(3);
        enable = 1'b1;
`ifdef SDRAM_WR_FLUSH_EN
        exp_len.push_back(credit);
        credit = 0;
        flush = 1'b1;
        drain("flush");
`else
        flush = 1'b1;
        expect_no_req("flush_disabled", 20);
`endif
        flush = 1'b0;

        // Random traffic with enable toggling; wraps the ring many times.
        for (int r = 0; r < 14; r++) begin
            push_words($urandom_range(1, 20));
            for (int j = 0; j < 4; j++) begin
                enable = ($urandom_range(0, 3) != 0);
                cycles($urandom_range(1, 12));
            end
        end
        drain("random");

        // Reset in the 4th READ cycle, then a fresh burst from BASE.
        push_words(BL);
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fifo_rd_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_read", 32'(ok), 32'd1);
        cycles(3);
        #1;
        clr_n = 1'b0;
        exp_len.delete();
        credit = 0;
        cycles(3);
        clr_n = 1'b1;
        push_words(BL);
        drain("after_reset");

        cycles(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
